// File: rtl/i2s_rx_ctrl.sv
// I2S capture sequencer: frame detection, channel select, decimation and a 32-bit sample FIFO.
// Build option: define I2S_RX_CTRL_SIGNEXT_EN to push 24-bit samples sign-extended to 32 bits.
module i2s_rx_ctrl #(
   parameter int DEPTH  = 16,
   parameter int AW     = 4,
   parameter int SETTLE = 2
) (
   input  logic          HCLK,
   input  logic          HRESET,
   input  logic          en,
   input  logic [1:0]    mode,
   input  logic [7:0]    decim,
   input  logic [AW:0]   thresh,
   input  logic          flush,
   input  logic          ws,
   input  logic [63:0]   rx_data,
   input  logic          rd_en,
   output logic [31:0]   rd_data,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   level,
   output logic          irq,
   output logic          ovr,
   input  logic          clr_ovr,
   output logic          mode_err,
   output logic          busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SYNC   = 3'd1,
      S_WAIT   = 3'd2,
      S_SETTLE = 3'd3,
      S_PUSH_L = 3'd4,
      S_PUSH_R = 3'd5
   } state_t;

   localparam logic [3:0]  SETTLE_W = 4'(SETTLE);
   localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);

   function automatic logic [31:0] fmt_word(input logic [31:0] d);
`ifdef I2S_RX_CTRL_SIGNEXT_EN
      return {{8{d[23]}}, d[23:0]};
`else
      return d;
`endif
   endfunction

   state_t        state_q, state_d;
   logic          ws_d_q;
   logic [3:0]    settle_q, settle_d;
   logic [7:0]    dcnt_q, dcnt_d;
   logic          both_q, both_d;
   logic          merr_q, merr_d;
   logic          busy_q;
   logic          edge_s;
   logic          push_s;
   logic          merr_set_s;
   logic [31:0]   push_word_s;

   logic [31:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic [31:0]   head_q, head_d;
   logic          empty_q, full_q;
   logic          irq_q;
   logic          ovr_q, ovr_d;
   logic          do_pop_s, do_push_s, ovr_set_s, wr_en_s;

   // Right channel just completed: a whole stereo frame is valid.
   assign edge_s = ws_d_q & ~ws;

   // Capture sequencer next-state logic.
   always_comb begin
      state_d     = state_q;
      settle_d    = settle_q;
      dcnt_d      = dcnt_q;
      both_d      = both_q;
      push_s      = 1'b0;
      push_word_s = 32'd0;
      merr_set_s  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (en) state_d = S_SYNC;
            else    state_d = S_IDLE;
         end
         S_SYNC: begin
            if (!en) begin
               state_d = S_IDLE;
            end else if (edge_s) begin
               state_d = S_WAIT;
               dcnt_d  = 8'd0;
            end else begin
               state_d = S_SYNC;
            end
         end
         S_WAIT: begin
            if (!en) begin
               state_d = S_IDLE;
            end else if (edge_s) begin
               state_d  = S_SETTLE;
               settle_d = SETTLE_W;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_SETTLE: begin
            if (!en) begin
               state_d = S_IDLE;
            end else if (settle_q != 4'd0) begin
               settle_d = settle_q - 4'd1;
            end else if (dcnt_q != 8'd0) begin
               dcnt_d  = dcnt_q - 8'd1;
               state_d = S_WAIT;
            end else begin
               dcnt_d = decim;
               // Mode is latched here so a pair in flight is unaffected by later changes.
               both_d = (mode == 2'b10);
               case (mode)
                  2'b00:   state_d = S_PUSH_L;
                  2'b01:   state_d = S_PUSH_R;
                  2'b10:   state_d = S_PUSH_L;
                  default: begin
                     merr_set_s = 1'b1;
                     state_d    = S_WAIT;
                  end
               endcase
            end
         end
         S_PUSH_L: begin
            push_s      = 1'b1;
            push_word_s = fmt_word(rx_data[31:0]);
            if (both_q) state_d = S_PUSH_R;
            else        state_d = S_WAIT;
         end
         S_PUSH_R: begin
            push_s      = 1'b1;
            push_word_s = fmt_word(rx_data[63:32]);
            state_d     = S_WAIT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign do_pop_s  = rd_en & ~empty_q;
   assign do_push_s = push_s & (~full_q | do_pop_s);
   assign ovr_set_s = push_s & full_q & ~do_pop_s & ~flush;
   assign wr_en_s   = do_push_s & ~flush;

   // FIFO pointer, level and registered head-word next-state logic.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      head_d   = head_q;
      if (flush) begin
         wr_ptr_d = {AW{1'b0}};
         rd_ptr_d = {AW{1'b0}};
         level_d  = {(AW+1){1'b0}};
         head_d   = 32'd0;
      end else begin
         wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, do_push_s};
         rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, do_pop_s};
         level_d  = level_q + {{AW{1'b0}}, do_push_s} - {{AW{1'b0}}, do_pop_s};
         if (level_d == {(AW+1){1'b0}}) begin
            head_d = 32'd0;
         end else if (level_q == {{AW{1'b0}}, do_pop_s}) begin
            // Storage holds nothing else: the word being written becomes the head.
            head_d = push_word_s;
         end else begin
            head_d = mem_q[rd_ptr_d];
         end
      end
   end

   // Sticky status next-state; a new event wins over a same-cycle clear.
   always_comb begin
      ovr_d  = ovr_q;
      merr_d = merr_q;
      if (ovr_set_s)    ovr_d = 1'b1;
      else if (clr_ovr) ovr_d = 1'b0;
      else              ovr_d = ovr_q;
      if (merr_set_s)   merr_d = 1'b1;
      else if (clr_ovr) merr_d = 1'b0;
      else              merr_d = merr_q;
   end

   // Sample storage; contents need no reset.
   always_ff @(posedge HCLK) begin
      if (wr_en_s) mem_q[wr_ptr_q] <= push_word_s;
   end

   // State and status registers.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q  <= S_IDLE;
         ws_d_q   <= 1'b0;
         settle_q <= 4'd0;
         dcnt_q   <= 8'd0;
         both_q   <= 1'b0;
         merr_q   <= 1'b0;
         busy_q   <= 1'b0;
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         level_q  <= {(AW+1){1'b0}};
         head_q   <= 32'd0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         irq_q    <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ws_d_q   <= ws;
         settle_q <= settle_d;
         dcnt_q   <= dcnt_d;
         both_q   <= both_d;
         merr_q   <= merr_d;
         busy_q   <= (state_d != S_IDLE);
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         head_q   <= head_d;
         empty_q  <= (level_d == {(AW+1){1'b0}});
         full_q   <= (level_d == DEPTH_W);
         irq_q    <= (thresh != {(AW+1){1'b0}}) && (level_q >= thresh);
         ovr_q    <= ovr_d;
      end
   end

   assign rd_data  = head_q;
   assign empty    = empty_q;
   assign full     = full_q;
   assign level    = level_q;
   assign irq      = irq_q;
   assign ovr      = ovr_q;
   assign mode_err = merr_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Self-checking bench for i2s_rx_ctrl: randomized frame data against a frame-level queue model.
// Honours I2S_RX_CTRL_SIGNEXT_EN in the same way as the design.
module tb_i2s_rx_ctrl;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          HCLK = 1'b0;
   logic          HRESET, en, flush, ws, rd_en, clr_ovr;
   logic [1:0]    mode;
   logic [7:0]    decim;
   logic [AW:0]   thresh;
   logic [63:0]   rx_data;
   logic [31:0]   rd_data;
   logic          empty, full, irq, ovr, mode_err, busy;
   logic [AW:0]   level;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int fail_cnt  = 0;

   logic [31:0] mq[$];
   bit  m_en, m_synced, m_ovr, m_merr;
   int  m_k, cur_mode, cur_decim;

   i2s_rx_ctrl #(.DEPTH(DEPTH), .AW(AW), .SETTLE(2)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .en(en), .mode(mode), .decim(decim),
      .thresh(thresh), .flush(flush), .ws(ws), .rx_data(rx_data), .rd_en(rd_en),
      .rd_data(rd_data), .empty(empty), .full(full), .level(level), .irq(irq),
      .ovr(ovr), .clr_ovr(clr_ovr), .mode_err(mode_err), .busy(busy)
   );

   always #5 HCLK = ~HCLK;

   function automatic logic [31:0] ref_word(input logic [31:0] w);
`ifdef I2S_RX_CTRL_SIGNEXT_EN
      return {{8{w[23]}}, w[23:0]};
`else
      return w;
`endif
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge HCLK);
      #1;
   endtask

   task automatic model_push(input logic [31:0] w);
      if (mq.size() == DEPTH) m_ovr = 1'b1;
      else                    mq.push_back(ref_word(w));
   endtask

   // One completed frame: the first after enabling is discarded, then 1 in decim+1 is kept.
   task automatic model_frame(input logic [63:0] d, input bit pre_pop);
      if (!m_en) return;
      if (!m_synced) begin
         m_synced = 1'b1;
         m_k      = 0;
         return;
      end
      if (m_k % (cur_decim + 1) == 0) begin
         if (pre_pop && mq.size() > 0) void'(mq.pop_front());
         case (cur_mode)
            0:       model_push(d[31:0]);
            1:       model_push(d[63:32]);
            2:       begin model_push(d[31:0]); model_push(d[63:32]); end
            default: m_merr = 1'b1;
         endcase
      end
      m_k++;
   endtask

   // opt: 0 plain, 1 push-latency check, 2 pop during push cycle, 3 drop en during first push.
   task automatic run_frame(input logic [63:0] d, input int opt);
      int lvl0;
      ws = 1'b1;
      rx_data = d;
      repeat (32) cyc();
      ws = 1'b0;
      lvl0 = int'(level);
      repeat (4) cyc();
      if (opt == 1) chk("latency_before", level, lvl0);
      if (opt == 2) begin
         chk("head_before_simul", rd_data, mq[0]);
         rd_en = 1'b1;
      end
      if (opt == 3) en = 1'b0;
      cyc();
      rd_en = 1'b0;
      if (opt == 1) chk("latency_at", level, lvl0 + 1);
      repeat (27) cyc();
      model_frame(d, opt == 2);
      if (opt == 3) m_en = 1'b0;
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_level"}, level, mq.size());
      chk({tag, "_empty"}, empty, mq.size() == 0);
      chk({tag, "_full"}, full, mq.size() == DEPTH);
      chk({tag, "_ovr"}, ovr, m_ovr);
      chk({tag, "_merr"}, mode_err, m_merr);
      if (mq.size() > 0) chk({tag, "_head"}, rd_data, mq[0]);
   endtask

   task automatic pop_one();
      chk("pop_head", rd_data, mq[0]);
      rd_en = 1'b1;
      cyc();
      rd_en = 1'b0;
      void'(mq.pop_front());
   endtask

   task automatic drain(input string tag);
      while (mq.size() > 0) pop_one();
      check_state(tag);
   endtask

   task automatic resync();
      en = 1'b0;
      repeat (3) cyc();
      en = 1'b1;
      cyc();
      m_en = 1'b1;
      m_synced = 1'b0;
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   initial begin
      HRESET = 1'b1; en = 1'b0; flush = 1'b0; ws = 1'b0; rd_en = 1'b0; clr_ovr = 1'b0;
      mode = 2'b00; decim = 8'd0; thresh = '0; rx_data = 64'd0;
      m_en = 1'b0; m_synced = 1'b0; m_ovr = 1'b0; m_merr = 1'b0; m_k = 0;
      cur_mode = 0; cur_decim = 0;
      repeat (3) cyc();
      HRESET = 1'b0;
      cyc();
      chk("rst_empty", empty, 1'b1);
      chk("rst_full", full, 1'b0);
      chk("rst_level", level, 0);
      chk("rst_irq", irq, 1'b0);
      chk("rst_ovr", ovr, 1'b0);
      chk("rst_merr", mode_err, 1'b0);
      chk("rst_rd_data", rd_data, 32'h0);
      chk("rst_busy", busy, 1'b0);

      // Left-only capture, fixed vector then random data
      en = 1'b1; m_en = 1'b1;
      cyc();
      chk("busy_on", busy, 1'b1);
      run_frame({32'hBBBB0002, 32'hAAAA0001}, 0);
      check_state("sync_discard");
      run_frame({32'hBBBB0002, 32'hAAAA0001}, 1);
      chk("first_word", rd_data, ref_word(32'hAAAA0001));
      repeat (2) run_frame(rnd64(), 0);
      check_state("left3");
      drain("left_drain");

      // Stereo pairs, then right only
      mode = 2'b10; cur_mode = 2;
      repeat (3) run_frame(rnd64(), 0);
      check_state("both6");
      drain("both_drain");
      mode = 2'b01; cur_mode = 1;
      repeat (2) run_frame(rnd64(), 0);
      check_state("right2");
      drain("right_drain");

      // Decimation keeps frames 1, 4 and 7 after sync
      mode = 2'b00; cur_mode = 0; decim = 8'd2; cur_decim = 2;
      resync();
      run_frame(rnd64(), 0);
      repeat (9) run_frame(rnd64(), 0);
      chk("decim_level", level, 3);
      check_state("decim");
      drain("decim_drain");

      // Overflow, then push with simultaneous pop while full
      decim = 8'd0; cur_decim = 0;
      resync();
      run_frame(rnd64(), 0);
      repeat (17) run_frame(rnd64(), 0);
      chk("ovf_full", full, 1'b1);
      chk("ovf_ovr", ovr, 1'b1);
      check_state("ovf");
      clr_ovr = 1'b1; cyc(); clr_ovr = 1'b0; m_ovr = 1'b0;
      chk("ovr_cleared", ovr, 1'b0);
      run_frame(rnd64(), 2);
      check_state("simul_full");
      drain("ovf_drain");

      // Threshold IRQ and flush
      thresh = 5'd4;
      repeat (3) run_frame(rnd64(), 0);
      chk("irq_below", irq, 1'b0);
      run_frame(rnd64(), 0);
      chk("irq_at4", irq, 1'b1);
      pop_one();
      chk("lvl_after_pop", level, 3);
      chk("irq_lag", irq, 1'b1);
      cyc();
      chk("irq_fall", irq, 1'b0);
      repeat (7) run_frame(rnd64(), 0);
      check_state("pre_flush");
      flush = 1'b1; cyc(); flush = 1'b0;
      mq.delete();
      chk("flush_level", level, 0);
      chk("flush_empty", empty, 1'b1);
      cyc();
      chk("flush_irq", irq, 1'b0);
      thresh = '0;

      // en dropped in the middle of a stereo pair
      mode = 2'b10; cur_mode = 2;
      run_frame(rnd64(), 3);
      check_state("en_drop");
      chk("en_drop_busy", busy, 1'b0);
      drain("en_drop_drain");

      // Reserved mode
      en = 1'b1; m_en = 1'b1; m_synced = 1'b0;
      run_frame(rnd64(), 0);
      mode = 2'b11; cur_mode = 3;
      run_frame(rnd64(), 0);
      chk("merr_set", mode_err, 1'b1);
      check_state("merr");
      clr_ovr = 1'b1; cyc(); clr_ovr = 1'b0; m_merr = 1'b0;
      chk("merr_clr", mode_err, 1'b0);

      // Sign-extension boundary word
      mode = 2'b00; cur_mode = 0;
      run_frame({32'hBBBB0002, 32'h00800000}, 0);
`ifdef I2S_RX_CTRL_SIGNEXT_EN
      chk("signext_word", rd_data, 32'hFF800000);
`else
      chk("raw_word", rd_data, 32'h00800000);
`endif
      run_frame(rnd64(), 0);
      check_state("pre_reset");

      // Reset mid-operation
      HRESET = 1'b1;
      cyc();
      chk("mid_rst_level", level, 0);
      chk("mid_rst_empty", empty, 1'b1);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_rd_data", rd_data, 32'h0);
      HRESET = 1'b0; en = 1'b0;
      cyc();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/i2s_rx_ctrl.md
Name: i2s_rx_ctrl

Overview:
Capture sequencer between the I2S receiver and the CPU-side peripheral wrapper. It detects completed stereo frames on the receiver's word-select, and selects left, right or both channel words according to the channel mode. It applies frame decimation and buffers the selected words in a 32-bit sample FIFO with level, threshold-IRQ and overrun reporting. It replaces direct register reads of the receiver's live shift data.

Parameters:
DEPTH, 16, FIFO depth in 32-bit words; power of two, minimum 4.
AW, 4, log2(DEPTH).
SETTLE, 2, HCLK cycles waited after a frame edge before sampling rx_data (range 1..15).

Ports:
HCLK  in  1  system clock
HRESET  in  1  synchronous active-high reset
en  in  1  capture enable (level)
mode  in  2  00 left, 01 right, 10 both (left then right), 11 reserved
decim  in  8  keep 1 of every decim+1 frames
thresh  in  AW+1  IRQ level threshold
flush  in  1  single-cycle FIFO clear
ws  in  1  word select from receiver (HCLK domain)
rx_data  in  64  receiver data: [31:0] left, [63:32] right
rd_en  in  1  pop request
rd_data  out  32  FIFO head word
empty  out  1  FIFO empty
full  out  1  FIFO full
level  out  AW+1  words stored, 0..DEPTH
irq  out  1  level >= thresh and thresh != 0
ovr  out  1  sticky overrun
clr_ovr  in  1  clears ovr
mode_err  out  1  sticky: capture attempted with mode 11; cleared by clr_ovr
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, FIFO pointers 0, level 0, empty=1, full=0, irq=0, ovr=0, mode_err=0, rd_data=0, decimation counter 0, ws_d=0.
- Frame edge: ws_d registers ws; edge = ws_d & ~ws (falling edge, 1→0), i.e. right channel complete, full frame valid.
- FSM:
  - IDLE: on en → SYNC.
  - SYNC: discards the partial frame. On the first edge → WAIT; decimation counter cleared.
  - WAIT: on edge → SETTLE, with settle counter loaded with SETTLE.
  - SETTLE: count down; at 0, evaluate the frame. If decim counter != 0, decrement and → WAIT (frame dropped). Otherwise reload counter with decim, then: mode 00 → PUSH_L; mode 01 → PUSH_R; mode 10 → PUSH_L; mode 11 → set mode_err, → WAIT.
  - PUSH_L: push rx_data[31:0]; → PUSH_R if mode==10, else → WAIT.
  - PUSH_R: push rx_data[63:32]; → WAIT.
- en low: checked in SYNC, WAIT and SETTLE only; goes → IDLE. PUSH_L/PUSH_R always complete, so a stereo pair is never split. mode and decim are sampled at the SETTLE exit only.
- FIFO:
  - rd_data is the registered head word, valid when !empty. rd_en is ignored when empty.
  - Push when full and no pop in the same cycle: word dropped, ovr set.
  - Push and pop in the same cycle while full: both happen, level unchanged, no ovr.
  - Push and pop in the same cycle while empty: push only.
  - Pointers wrap modulo DEPTH.
  - Pushes are one per cycle; level updates the cycle after the push or pop.
- flush: resets pointers and level the next cycle and has priority over same-cycle push and pop. FSM and ovr are unaffected.
- irq is registered from the updated level (one cycle after the level change).
- clr_ovr: if a clear and a new overrun coincide, set wins.
- HRESET mid-operation: immediate return to the reset state; FIFO contents are lost.

Optional Feature:
I2S_RX_CTRL_SIGNEXT_EN: when defined, each pushed word is {{8{d[23]}}, d[23:0]}, i.e. a 24-bit sample sign-extended into 32 bits. When undefined, the 32-bit channel word is pushed unmodified. There is no port or timing difference between the two builds.

Test Plan:
- Reset then en=1, mode=00, decim=0, SETTLE=2, ws toggling with a 64-cycle frame and rx_data={32'hBBBB0002,32'hAAAA0001}: the first edge is discarded; from the second edge, one push per frame; rd_data=32'hAAAA0001; level increments 2+SETTLE+1 cycles after the edge.
- mode=10, 3 frames: 6 words, ordered L,R,L,R,L,R; mode=01 pushes the 32'hBBBB.... words only.
- decim=2, 9 frames after sync: exactly 3 pushes, on sync-relative frames 1, 4 and 7.
- DEPTH=16 with no reads for 17 left pushes: full=1, level=16, ovr=1, the 17th word is absent. Push with simultaneous rd_en while full: ovr stays 0 and level stays 16.
- thresh=4: irq rises the cycle after level reaches 4 and falls after a pop to 3. flush with level=10: level=0 and empty=1 next cycle, irq=0.
- en dropped during PUSH_L with mode=10: PUSH_R still occurs, then IDLE, busy=0. mode=11 frame: mode_err=1 with no push. With the macro defined, rx_data[31:0]=32'h00800000 pops as 32'hFF800000.
